// File: rtl/mux16_sched_pkg.sv
// Shared types and helpers for the 16-way round-robin mux scheduler.
package mux16_sched_pkg;

  localparam int NREQ = 16;
  localparam int SELW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  function automatic logic [NREQ-1:0] onehot16(input logic [SELW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux16to1.sv
// Single-bit 16:1 multiplexer used on the shared serial output path.
module mux16to1 (
  input  logic [15:0] in,
  input  logic [3:0]  sel,
  output logic        out
);

  assign out = in[sel];

endmodule

// File: rtl/rr_pick16.sv
// Round-robin picker: first set request at or after ptr, wrapping 15 -> 0.
module rr_pick16
  import mux16_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SELW-1:0]   off;

  // Bit i of rot is req[(ptr + i) mod 16], so offset 0 is the search start.
  assign dbl = {req, req};
  assign rot = NREQ'(dbl >> ptr);

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SELW'(i);
    end
  end

  assign any = |req;
  assign idx = ptr + off;

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16 requesters,
// with per-grant hold limit and back-to-back handover.
//
// state | meaning
// IDLE  | no grant; waiting for any request
// GRANT | grant active on sel; released on request drop or hold limit
module mux16_rr_sched
  import mux16_sched_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  output logic [SELW-1:0] sel,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic            dout
);

  localparam int              CNTW     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD - 1);

  sched_state_e    state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            valid_q, valid_d;

  logic            rel;
  logic [SELW-1:0] pick_ptr;
  logic [SELW-1:0] pick_idx;
  logic            pick_any;
  logic            mux_out;

  // Request drop and hold limit collapse into one release event.
  assign rel      = (state_q == GRANT) && (!req[sel_q] || (cnt_q == CNT_LAST));
  assign pick_ptr = (state_q == GRANT) ? sel_q + SELW'(1) : ptr_q;

  rr_pick16 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = GRANT;
      GRANT:   if (rel && !pick_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          gnt_d   = onehot16(pick_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = pick_ptr;
          cnt_d = '0;
          if (pick_any) begin
            sel_d   = pick_idx;
            gnt_d   = onehot16(pick_idx);
            valid_d = 1'b1;
          end else begin
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  mux16to1 u_mux (
    .in  (din),
    .sel (sel_q),
    .out (mux_out)
  );

  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = valid_q;
  assign dout  = mux_out & valid_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: HOLD=4 and HOLD=1 instances.
module tb_mux16_rr_sched;

  typedef struct {
    logic [15:0] req;
    logic [15:0] din;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        valid;
    logic        dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req4, din4, gnt4, req1, din1, gnt1;
  logic [3:0]  sel4, sel1;
  logic        valid4, dout4, valid1, dout1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux16_rr_sched #(.HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .din(din4),
    .sel(sel4), .gnt(gnt4), .valid(valid4), .dout(dout4)
  );

  mux16_rr_sched #(.HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .din(din1),
    .sel(sel1), .gnt(gnt1), .valid(valid1), .dout(dout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[26];
  int   dseq[16];

  initial begin
    for (int i = 0; i < 4; i++) tbl[i] = '{16'h8001, 16'h0001, 4'd0, 16'h0001, 1'b1, 1'b1};
    for (int i = 4; i < 8; i++) tbl[i] = '{16'h8001, 16'h0001, 4'd15, 16'h8000, 1'b1, 1'b0};
    tbl[8]  = '{16'h8001, 16'h0001, 4'd0, 16'h0001, 1'b1, 1'b1};
    tbl[9]  = '{16'h0000, 16'h0001, 4'd0, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{16'h0024, 16'h0024, 4'd2, 16'h0004, 1'b1, 1'b1};
    tbl[11] = '{16'h0024, 16'h0024, 4'd2, 16'h0004, 1'b1, 1'b1};
    tbl[12] = '{16'h0020, 16'h0024, 4'd5, 16'h0020, 1'b1, 1'b1};
    tbl[13] = '{16'h0020, 16'h0024, 4'd5, 16'h0020, 1'b1, 1'b1};
    tbl[14] = '{16'h0060, 16'h0024, 4'd5, 16'h0020, 1'b1, 1'b1};
    tbl[15] = '{16'h0060, 16'h0024, 4'd5, 16'h0020, 1'b1, 1'b1};
    tbl[16] = '{16'h0060, 16'h0024, 4'd6, 16'h0040, 1'b1, 1'b0};
    tbl[17] = '{16'h0000, 16'h0040, 4'd6, 16'h0000, 1'b0, 1'b0};
    for (int i = 18; i < 21; i++) tbl[i] = '{16'h0003, 16'h0002, 4'd0, 16'h0001, 1'b1, 1'b0};
    tbl[21] = '{16'h0002, 16'h0002, 4'd1, 16'h0002, 1'b1, 1'b1};
    for (int i = 22; i < 25; i++) tbl[i] = '{16'h0003, 16'h0002, 4'd1, 16'h0002, 1'b1, 1'b1};
    tbl[25] = '{16'h0003, 16'h0002, 4'd0, 16'h0001, 1'b1, 1'b0};
    dseq = '{1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    rst_n = 1'b0;
    req4 = '0; din4 = 16'hFFFF; req1 = '0; din1 = 16'hFFFF;
    #12;
    chk("rst sel4", sel4, 0);
    chk("rst gnt4", gnt4, 0);
    chk("rst valid4", valid4, 0);
    chk("rst dout4", dout4, 0);
    chk("rst valid1", valid1, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("idle valid4", valid4, 0);
    chk("idle dout4", dout4, 0);

    // HOLD=1 sweep over all requesters with a fixed data pattern
    req1 = 16'hFFFF; din1 = 16'h3C5D;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("sweep sel1[%0d]", i), sel1, i);
      chk($sformatf("sweep valid1[%0d]", i), valid1, 1);
      chk($sformatf("sweep dout1[%0d]", i), dout1, dseq[i]);
    end
    req1 = 16'h0400;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("lone sel1[%0d]", i), sel1, 10);
      chk($sformatf("lone gnt1[%0d]", i), gnt1, 16'h0400);
      chk($sformatf("lone valid1[%0d]", i), valid1, 1);
    end
    req1 = 16'h0000;
    step();
    chk("drop valid1", valid1, 0);
    chk("drop gnt1", gnt1, 0);
    chk("drop sel1", sel1, 10);
    chk("drop dout1", dout1, 0);

    for (int i = 0; i < 26; i++) begin
      req4 = tbl[i].req;
      din4 = tbl[i].din;
      step();
      chk($sformatf("tbl sel4[%0d]", i), sel4, tbl[i].sel);
      chk($sformatf("tbl gnt4[%0d]", i), gnt4, tbl[i].gnt);
      chk($sformatf("tbl valid4[%0d]", i), valid4, tbl[i].valid);
      chk($sformatf("tbl dout4[%0d]", i), dout4, tbl[i].dout);
    end

    // reset asserted in the middle of a grant, then a fresh pick from index 0
    req4 = 16'h0100; din4 = 16'h0101;
    step();
    chk("pre-rst sel4", sel4, 8);
    chk("pre-rst dout4", dout4, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async sel4", sel4, 0);
    chk("async gnt4", gnt4, 0);
    chk("async valid4", valid4, 0);
    chk("async dout4", dout4, 0);
    req4 = 16'h0101;
    #2 rst_n = 1'b1;
    step();
    chk("post-rst sel4", sel4, 0);
    chk("post-rst gnt4", gnt4, 16'h0001);
    chk("post-rst valid4", valid4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
